// File: rtl/adder_run_sequencer.sv
// Register-programmed read/write address sequencer for the adder characterisation RAMs.
// readdata has a one-cycle latency, the slave never stalls, and the write side trails the read side by LATENCY cycles.
module adder_run_sequencer #(
  parameter int          ADDR_WIDTH = 9,
  parameter int          LAT_W      = 4,
  parameter logic [31:0] ID         = 32'd9
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  read,
  input  logic                  write,
  input  logic [2:0]            address,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  r_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic                  we,
  output logic                  busy,
  output logic                  done_irq
);

  localparam int          DL_DEPTH  = (1 << LAT_W) - 1;
  localparam logic [31:0] MAX_COUNT = 32'(1) << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [LAT_W-1:0]      latency_q, latency_d;
  logic [LAT_W-1:0]      lat_run_q, lat_run_d;
  logic [LAT_W-1:0]      drain_q, drain_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
  logic                  r_en_q, r_en_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;
  logic                  done_irq_q, done_irq_d;
  logic [31:0]           cycles_q, cycles_d;
  logic [31:0]           readdata_q, readdata_d;
  logic [ADDR_WIDTH-1:0] dl_addr_q [DL_DEPTH];
  logic [ADDR_WIDTH-1:0] dl_addr_d [DL_DEPTH];
  logic [DL_DEPTH-1:0]   dl_en_q, dl_en_d;

  logic                  is_busy;
  logic                  wr_ctrl;
  logic                  wr_status;
  logic                  start;
  logic                  abort;
  logic                  last_addr;
  logic                  dl_flush;
  logic [LAT_W-1:0]      lat_idx;

  assign is_busy   = (state_q != IDLE);
  assign wr_ctrl   = write && (address == 3'd1);
  assign wr_status = write && (address == 3'd4);
  assign start     = wr_ctrl && writedata[0];
  assign abort     = wr_ctrl && writedata[1];
  assign last_addr = ({1'b0, r_addr_q} == (count_q - (ADDR_WIDTH+1)'(1)));

  // Counts above the address space are clamped so a run always terminates.
  always_comb begin
    count_d   = count_q;
    latency_d = latency_q;
    if (write && !is_busy) begin
      if (address == 3'd2) begin
        count_d = (writedata > MAX_COUNT) ? MAX_COUNT[ADDR_WIDTH:0] : writedata[ADDR_WIDTH:0];
      end
      if (address == 3'd3) begin
        latency_d = writedata[LAT_W-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    r_addr_d   = r_addr_q;
    r_en_d     = 1'b0;
    lat_run_d  = lat_run_q;
    drain_d    = drain_q;
    done_d     = done_q;
    aborted_d  = aborted_q;
    done_irq_d = 1'b0;
    dl_flush   = 1'b0;
    cycles_d   = (is_busy && (cycles_q != '1)) ? cycles_q + 32'd1 : cycles_q;

    if (wr_status) begin
      if (writedata[1]) done_d = 1'b0;
      if (writedata[2]) aborted_d = 1'b0;
    end

    if (abort) begin
      state_d   = IDLE;
      aborted_d = 1'b1;
      dl_flush  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (count_q != '0) begin
              state_d   = RUN;
              r_addr_d  = '0;
              r_en_d    = 1'b1;
              lat_run_d = latency_q;
              done_d    = 1'b0;
              aborted_d = 1'b0;
              cycles_d  = '0;
              // Clear stale enables so a longer latency never replays the previous run.
              dl_flush  = 1'b1;
            end else begin
              done_d     = 1'b1;
              done_irq_d = 1'b1;
            end
          end
        end
        RUN: begin
          if (last_addr) begin
            if (lat_run_q == '0) begin
              state_d    = IDLE;
              done_d     = 1'b1;
              done_irq_d = 1'b1;
            end else begin
              state_d = DRAIN;
              drain_d = lat_run_q - LAT_W'(1);
            end
          end else begin
            r_addr_d = r_addr_q + ADDR_WIDTH'(1);
            r_en_d   = 1'b1;
          end
        end
        DRAIN: begin
          if (drain_q == '0) begin
            state_d    = IDLE;
            done_d     = 1'b1;
            done_irq_d = 1'b1;
          end else begin
            drain_d = drain_q - LAT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    dl_addr_d[0] = r_addr_q;
    dl_en_d[0]   = r_en_q && !dl_flush;
    for (int i = 1; i < DL_DEPTH; i++) begin
      dl_addr_d[i] = dl_addr_q[i-1];
      dl_en_d[i]   = dl_en_q[i-1] && !dl_flush;
    end
  end

  always_comb begin
    readdata_d = readdata_q;
    if (read) begin
      case (address)
        3'd0:    readdata_d = ID;
        3'd2:    readdata_d = 32'(count_q);
        3'd3:    readdata_d = 32'(latency_q);
        3'd4:    readdata_d = {29'd0, aborted_q, done_q, is_busy};
        3'd5:    readdata_d = cycles_q;
        default: readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= IDLE;
      count_q    <= '0;
      latency_q  <= '0;
      lat_run_q  <= '0;
      drain_q    <= '0;
      r_addr_q   <= '0;
      r_en_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      done_irq_q <= 1'b0;
      cycles_q   <= '0;
      readdata_q <= '0;
      dl_en_q    <= '0;
      for (int i = 0; i < DL_DEPTH; i++) dl_addr_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      latency_q  <= latency_d;
      lat_run_q  <= lat_run_d;
      drain_q    <= drain_d;
      r_addr_q   <= r_addr_d;
      r_en_q     <= r_en_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      done_irq_q <= done_irq_d;
      cycles_q   <= cycles_d;
      readdata_q <= readdata_d;
      dl_en_q    <= dl_en_d;
      for (int i = 0; i < DL_DEPTH; i++) dl_addr_q[i] <= dl_addr_d[i];
    end
  end

  assign lat_idx  = lat_run_q - LAT_W'(1);
  assign r_addr   = r_addr_q;
  assign r_en     = r_en_q;
  assign w_addr   = (lat_run_q == '0) ? r_addr_q : dl_addr_q[lat_idx];
  assign we       = (lat_run_q == '0) ? r_en_q : dl_en_q[lat_idx];
  assign busy     = is_busy;
  assign done_irq = done_irq_q;
  assign readdata = readdata_q;

endmodule

// File: tb/tb_adder_run_sequencer.sv
// Bench for adder_run_sequencer: table of runs, hand-written corner sequences and random runs vs a timing model.
module tb_adder_run_sequencer;

  localparam int AW = 9;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [2:0]    address = 3'd0;
  logic [31:0]   writedata = 32'd0;
  logic [31:0]   readdata;
  logic [AW-1:0] r_addr;
  logic          r_en;
  logic [AW-1:0] w_addr;
  logic          we;
  logic          busy;
  logic          done_irq;

  int total = 0;
  int bad   = 0;

  adder_run_sequencer #(.ADDR_WIDTH(AW), .LAT_W(4), .ID(32'd9)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .read      (read),
    .write     (write),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata),
    .r_addr    (r_addr),
    .r_en      (r_en),
    .w_addr    (w_addr),
    .we        (we),
    .busy      (busy),
    .done_irq  (done_irq)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cnt;
    int          lat;
    int          ab_at;
    int          pk_at;
    logic [31:0] st;
    logic [31:0] cy;
  } vec_t;

  function automatic int imin(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    write = 1'b1; address = a; writedata = d;
    tick();
    write = 1'b0; writedata = 32'd0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    read = 1'b1; address = a;
    tick();
    read = 1'b0;
    d = readdata;
  endtask

  // Expected waveform after edge k+t for a run of c vectors at latency l,
  // optionally aborted by a write captured at edge k+ab (ab>0), optionally
  // poked with ignored COUNT/LATENCY/start writes at edges k+pk..k+pk+2.
  task automatic run_check(input string name, input int c, input int l, input int ab, input int pk,
                           input logic [31:0] exp_st, input logic [31:0] exp_cy);
    logic [21:0] exp_v, act_v;
    logic [31:0] rd;
    bit          gone, e_ren, e_we, e_busy, e_irq;
    int          e_ra, e_wa;
    write = 1'b1; address = 3'd1; writedata = 32'd1;
    tick();
    for (int t = 0; t <= c + l + 2; t++) begin
      gone   = (ab > 0) && (t >= ab);
      e_ren  = !gone && (t < c);
      e_ra   = gone ? imin(ab - 1, c - 1) : imin(t, c - 1);
      e_we   = !gone && (t >= l) && (t < l + c);
      e_wa   = e_we ? t - l : 0;
      e_busy = !gone && (t < c + l);
      e_irq  = !gone && (t == c + l);
      exp_v  = {e_busy, e_ren, e_we, e_irq, AW'(e_ra), AW'(e_wa)};
      act_v  = {busy, r_en, we, done_irq, r_addr, (e_we ? w_addr : '0)};
      check($sformatf("%s t=%0d {busy,r_en,we,irq,r_addr,w_addr}", name, t), act_v, exp_v);
      write = 1'b0; writedata = 32'd0;
      if (ab > 0 && t + 1 == ab) begin write = 1'b1; address = 3'd1; writedata = 32'd2; end
      if (pk > 0 && t + 1 == pk) begin write = 1'b1; address = 3'd2; writedata = 32'd3; end
      if (pk > 0 && t + 1 == pk + 1) begin write = 1'b1; address = 3'd3; writedata = 32'd7; end
      if (pk > 0 && t + 1 == pk + 2) begin write = 1'b1; address = 3'd1; writedata = 32'd1; end
      tick();
    end
    write = 1'b0; writedata = 32'd0;
    bus_read(3'd4, rd);
    check({name, " STATUS"}, rd, exp_st);
    bus_read(3'd5, rd);
    check({name, " CYCLES"}, rd, exp_cy);
    bus_read(3'd2, rd);
    check({name, " COUNT readback"}, rd, c);
    bus_read(3'd3, rd);
    check({name, " LATENCY readback"}, rd, l);
  endtask

  initial begin
    logic [31:0] rd;
    vec_t        tbl[7];
    int          c, l, ab, pk, n;

    tbl[0] = '{8,   3,  0,  0, 32'd2, 32'd11};
    tbl[1] = '{512, 0,  0,  0, 32'd2, 32'd512};
    tbl[2] = '{50,  5,  20, 0, 32'd4, 32'd20};
    tbl[3] = '{10,  2,  0,  3, 32'd2, 32'd12};
    tbl[4] = '{5,   15, 3,  0, 32'd4, 32'd3};
    tbl[5] = '{1,   0,  0,  0, 32'd2, 32'd1};
    tbl[6] = '{1,   15, 0,  0, 32'd2, 32'd16};

    resetn = 1'b0;
    repeat (3) tick();
    check("reset outputs", {readdata, busy, r_en, we, done_irq, r_addr, w_addr}, 64'd0);
    resetn = 1'b1;
    tick();
    bus_read(3'd4, rd); check("reset STATUS", rd, 32'd0);
    bus_read(3'd2, rd); check("reset COUNT", rd, 32'd0);
    bus_read(3'd3, rd); check("reset LATENCY", rd, 32'd0);
    bus_read(3'd5, rd); check("reset CYCLES", rd, 32'd0);
    bus_write(3'd7, 32'hFFFF_FFFF);
    bus_read(3'd7, rd); check("unused addr 7", rd, 32'd0);
    bus_read(3'd6, rd); check("unused addr 6", rd, 32'd0);
    bus_read(3'd1, rd); check("CTRL reads 0", rd, 32'd0);
    bus_read(3'd0, rd); check("ID", rd, 32'd9);
    repeat (3) tick();
    check("readdata holds", readdata, 32'd9);

    for (int i = 0; i < 7; i++) begin
      bus_write(3'd2, tbl[i].cnt);
      bus_write(3'd3, tbl[i].lat);
      run_check($sformatf("tbl%0d", i), tbl[i].cnt, tbl[i].lat, tbl[i].ab_at, tbl[i].pk_at,
                tbl[i].st, tbl[i].cy);
    end

    bus_write(3'd4, 32'h2);
    bus_read(3'd4, rd); check("clear done", rd, 32'd0);

    // COUNT=0: done without any memory traffic.
    bus_write(3'd2, 32'd0);
    write = 1'b1; address = 3'd1; writedata = 32'd1;
    tick();
    write = 1'b0; writedata = 32'd0;
    for (int t = 0; t < 8; t++) begin
      check($sformatf("count0 t=%0d {busy,r_en,we,irq}", t), {busy, r_en, we, done_irq},
            {3'b000, (t == 0)});
      tick();
    end
    bus_read(3'd4, rd); check("count0 STATUS", rd, 32'd2);

    // Start and abort in one write while idle.
    bus_write(3'd4, 32'h6);
    bus_write(3'd2, 32'd4);
    write = 1'b1; address = 3'd1; writedata = 32'd3;
    tick();
    write = 1'b0; writedata = 32'd0;
    for (int t = 0; t < 6; t++) begin
      check($sformatf("start+abort t=%0d {busy,r_en,we,irq}", t), {busy, r_en, we, done_irq}, 4'b0000);
      tick();
    end
    bus_read(3'd4, rd); check("start+abort STATUS", rd, 32'd4);
    bus_write(3'd4, 32'h6);
    bus_read(3'd4, rd); check("STATUS cleared", rd, 32'd0);

    for (int i = 0; i < 30; i++) begin
      c  = $urandom_range(1, 60);
      l  = $urandom_range(0, 15);
      ab = 0;
      pk = 0;
      case ($urandom_range(0, 3))
        0: ab = $urandom_range(1, c + l);
        1: if (c + l >= 4) pk = $urandom_range(1, c + l - 2);
        default: ;
      endcase
      bus_write(3'd2, c);
      bus_write(3'd3, l);
      run_check($sformatf("rnd%0d c=%0d l=%0d ab=%0d pk=%0d", i, c, l, ab, pk), c, l, ab, pk,
                (ab > 0) ? 32'd4 : 32'd2, (ab > 0) ? ab : c + l);
    end

    // Reset in the middle of a long run.
    bus_write(3'd2, 32'd100);
    bus_write(3'd3, 32'd6);
    bus_read(3'd0, rd);
    bus_write(3'd1, 32'd1);
    repeat (39) tick();
    check("pre-reset busy", busy, 1'b1);
    resetn = 1'b0;
    tick();
    check("mid-run reset outputs", {readdata, busy, r_en, we, done_irq, r_addr, w_addr}, 64'd0);
    resetn = 1'b1;
    n = 0;
    repeat (120) begin
      tick();
      if (done_irq || busy || r_en || we) n++;
    end
    check("post-reset activity cycles", n, 0);
    bus_read(3'd4, rd); check("post-reset STATUS", rd, 32'd0);
    bus_read(3'd2, rd); check("post-reset COUNT", rd, 32'd0);
    bus_read(3'd5, rd); check("post-reset CYCLES", rd, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
